// File: rtl/riscv_instr_aligner_if.sv
// Handshake bundles around the instruction aligner: the fetch side (prefetch
// buffer plus redirect) and the instruction side (towards the decoder).

interface aligner_fetch_if;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    // master = prefetch buffer / redirect source, slave = aligner
    modport master (
        output fetch_valid_i, fetch_rdata_i, fetch_addr_i, branch_i, branch_addr_i,
        input  fetch_ready_o
    );
    modport slave (
        input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, branch_i, branch_addr_i,
        output fetch_ready_o
    );
endinterface

interface aligner_instr_if;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;

    // master = aligner, slave = compressed decoder
    modport master (
        output instr_valid_o, instr_rdata_o, instr_addr_o,
        input  instr_ready_i
    );
    modport slave (
        input  instr_valid_o, instr_rdata_o, instr_addr_o,
        output instr_ready_i
    );
endinterface

// File: rtl/riscv_instr_aligner.sv
// IF-stage aligner: turns word-aligned fetch words into one instruction per
// handshake, carrying a single residue halfword for straddles and odd redirects.

module riscv_instr_aligner (
    input  logic            clk,
    input  logic            rst_n,
    aligner_fetch_if.slave  fetch,
    aligner_instr_if.master instr
);

    typedef enum logic [1:0] {
        ALIGNED  = 2'd0,
        RESIDUE  = 2'd1,
        SKIP_LOW = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] res_reg, res_next;
    logic [31:0] res_addr_reg, res_addr_next;

    logic        valid_comb;
    logic        fready_comb;
    logic [31:0] rdata_comb;
    logic [31:0] addr_comb;
    logic        instr_hs;

    logic [31:0] word;
    logic [31:0] word_addr;
    logic        res_is_32;

    assign word      = fetch.fetch_rdata_i;
    assign word_addr = fetch.fetch_addr_i;
    assign res_is_32 = (res_reg[1:0] == 2'b11);

    // Only the halfword-select bit of the redirect target matters here.
    logic unused_bits;
    assign unused_bits = ^{fetch.branch_addr_i[31:2], fetch.branch_addr_i[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ALIGNED;
            res_reg      <= 16'h0;
            res_addr_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            res_reg      <= res_next;
            res_addr_reg <= res_addr_next;
        end
    end

    // Output process: everything combinational from state, residue and fetch inputs.
    always_comb begin
        valid_comb  = 1'b0;
        fready_comb = 1'b0;
        rdata_comb  = 32'h0;
        addr_comb   = 32'h0;
        case (state_reg)
            ALIGNED: begin
                valid_comb  = fetch.fetch_valid_i;
                addr_comb   = word_addr;
                rdata_comb  = (word[1:0] == 2'b11) ? word : {16'h0, word[15:0]};
                fready_comb = instr.instr_ready_i & fetch.fetch_valid_i;
            end
            RESIDUE: begin
                addr_comb = res_addr_reg;
                if (!res_is_32) begin
                    valid_comb = 1'b1;
                    rdata_comb = {16'h0, res_reg};
                end else begin
                    valid_comb  = fetch.fetch_valid_i;
                    rdata_comb  = {word[15:0], res_reg};
                    fready_comb = instr.instr_ready_i & fetch.fetch_valid_i;
                end
            end
            SKIP_LOW: begin
                fready_comb = 1'b1;
            end
            default: ;
        endcase
        // A redirect or reset kills both handshakes in the current cycle.
        if (fetch.branch_i || !rst_n) begin
            valid_comb  = 1'b0;
            fready_comb = 1'b0;
        end
    end

    assign instr_hs = valid_comb & instr.instr_ready_i;

    always_comb begin
        state_next    = state_reg;
        res_next      = res_reg;
        res_addr_next = res_addr_reg;
        if (fetch.branch_i) begin
            state_next = fetch.branch_addr_i[1] ? SKIP_LOW : ALIGNED;
            res_next   = 16'h0;
        end else begin
            case (state_reg)
                ALIGNED: begin
                    if (instr_hs && word[1:0] != 2'b11) begin
                        res_next      = word[31:16];
                        res_addr_next = word_addr + 32'd2;
                        state_next    = RESIDUE;
                    end
                end
                RESIDUE: begin
                    if (instr_hs) begin
                        if (!res_is_32) begin
                            state_next = ALIGNED;
                        end else begin
                            res_next      = word[31:16];
                            res_addr_next = word_addr + 32'd2;
                        end
                    end
                end
                SKIP_LOW: begin
                    if (fetch.fetch_valid_i) begin
                        res_next      = word[31:16];
                        res_addr_next = word_addr + 32'd2;
                        state_next    = RESIDUE;
                    end
                end
                default: state_next = ALIGNED;
            endcase
        end
    end

    assign fetch.fetch_ready_o = fready_comb;
    assign instr.instr_valid_o = valid_comb;
    assign instr.instr_rdata_o = rdata_comb;
    assign instr.instr_addr_o  = addr_comb;

endmodule
